// File: rtl/oreg_sched.sv
// Two-requester round-robin scheduler driving a registered output word that is held for
// HOLD cycles per grant, with a completion pulse to the owner on the last held cycle.
module oreg_sched #(
   parameter int unsigned HOLD = 4,
   parameter int unsigned W    = 5
) (
   input  logic         CK,
   input  logic         RSTN,
   input  logic         EN,
   input  logic         REQA,
   input  logic [W-1:0] DA,
   input  logic         REQB,
   input  logic [W-1:0] DB,
   output logic [W-1:0] Q,
   output logic         QV,
   output logic         GNTA,
   output logic         GNTB,
   output logic         ACKA,
   output logic         ACKB
);

   // One-hot encoding so corrupted values are distinguishable and recover to idle.
   typedef enum logic [1:0] {
      StIdle = 2'b01,
      StHold = 2'b10
   } state_e;

   localparam logic [3:0] CntLoad = 4'(HOLD - 1);

   state_e       state_q;
   logic [3:0]   cnt_q;
   logic         last_q;  // 1: B was served last
   logic [W-1:0] q_q;
   logic         qv_q;
   logic         gnta_q;
   logic         gntb_q;

   logic         any_req;
   logic         pick_a;
   logic         owner_req;
   logic         done;

   always_comb begin
      any_req   = REQA | REQB;
      pick_a    = REQA & (~REQB | last_q);
      owner_req = gnta_q ? REQA : REQB;
      done      = (state_q == StHold) && (cnt_q == 4'd0);
   end

   always_ff @(posedge CK) begin
      if (!RSTN) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         last_q  <= 1'b1;
         q_q     <= '0;
         qv_q    <= 1'b0;
         gnta_q  <= 1'b0;
         gntb_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (EN && any_req) begin
                  state_q <= StHold;
                  cnt_q   <= CntLoad;
                  last_q  <= ~pick_a;
                  q_q     <= pick_a ? DA : DB;
                  qv_q    <= 1'b1;
                  gnta_q  <= pick_a;
                  gntb_q  <= ~pick_a;
               end
            end
            StHold: begin
               if (cnt_q != 4'd0 && owner_req) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  // Completion or abort: drop ownership but keep Q and LAST.
                  state_q <= StIdle;
                  cnt_q   <= 4'd0;
                  qv_q    <= 1'b0;
                  gnta_q  <= 1'b0;
                  gntb_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= 4'd0;
               qv_q    <= 1'b0;
               gnta_q  <= 1'b0;
               gntb_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Q    = q_q;
   assign QV   = qv_q;
   assign GNTA = gnta_q;
   assign GNTB = gntb_q;
   assign ACKA = done & gnta_q;
   assign ACKB = done & gntb_q;

endmodule

// File: tb/tb_oreg_sched.sv
// Self-checking bench for oreg_sched: table-driven single grants with a scoreboard,
// plus hand sequences for alternation, abort, enable gating, reset and HOLD=1.
module tb_oreg_sched;

   localparam int W = 5;

   logic         CK = 1'b0;
   logic         RSTN = 1'b0;
   logic         EN = 1'b0;
   logic         REQA = 1'b0;
   logic         REQB = 1'b0;
   logic [W-1:0] DA = '0;
   logic [W-1:0] DB = '0;

   logic [W-1:0] q, q1;
   logic         qv, gnta, gntb, acka, ackb;
   logic         qv1, gnta1, gntb1, acka1, ackb1;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic         reqa;
      logic         reqb;
      logic [W-1:0] da;
      logic [W-1:0] db;
      logic [W-1:0] exp_q;
      logic         exp_a;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic         a;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];

   always #5 CK = ~CK;

   oreg_sched #(.HOLD(4), .W(W)) dut (
      .CK(CK), .RSTN(RSTN), .EN(EN), .REQA(REQA), .DA(DA), .REQB(REQB), .DB(DB),
      .Q(q), .QV(qv), .GNTA(gnta), .GNTB(gntb), .ACKA(acka), .ACKB(ackb)
   );

   oreg_sched #(.HOLD(1), .W(W)) dut1 (
      .CK(CK), .RSTN(RSTN), .EN(EN), .REQA(REQA), .DA(DA), .REQB(REQB), .DB(DB),
      .Q(q1), .QV(qv1), .GNTA(gnta1), .GNTB(gntb1), .ACKA(acka1), .ACKB(ackb1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge CK);
      RSTN = 1'b0;
      REQA = 1'b0;
      REQB = 1'b0;
      EN   = 1'b1;
      repeat (2) @(negedge CK);
      RSTN = 1'b1;
   endtask

   task automatic run_grant(input vec_t v);
      exp_t e;
      int   n;
      @(negedge CK);
      REQA = v.reqa;
      REQB = v.reqb;
      DA   = v.da;
      DB   = v.db;
      sb.push_back('{q: v.exp_q, a: v.exp_a});
      n = 0;
      do begin
         @(negedge CK);
         n++;
      end while (!qv && n < 8);
      chk("grant_seen", 32'(qv), 32'd1);
      e = sb.pop_front();
      if (qv) begin
         chk("grant_q", 32'(q), 32'(e.q));
         chk("grant_gnta", 32'(gnta), 32'(e.a));
         chk("grant_gntb", 32'(gntb), 32'(!e.a));
         for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge CK);
            chk("hold_q", 32'(q), 32'(e.q));
            chk("hold_qv", 32'(qv), 32'd1);
            chk("hold_acka", 32'(acka), 32'(e.a && k == 4));
            chk("hold_ackb", 32'(ackb), 32'(!e.a && k == 4));
            DA = 5'($urandom);
            DB = 5'($urandom);
         end
         REQA = 1'b0;
         REQB = 1'b0;
         @(negedge CK);
         chk("post_qv", 32'(qv), 32'd0);
         chk("post_gnt", 32'({gnta, gntb}), 32'd0);
         chk("post_q", 32'(q), 32'(e.q));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   ngr;
      int   idle_run;
      logic prev;

      // Fresh reset holds LAST=B, so the first contended grant goes to A.
      vecs[0] = '{1'b1, 1'b0, 5'h15, 5'h00, 5'h15, 1'b1};
      vecs[1] = '{1'b1, 1'b1, 5'h01, 5'h1E, 5'h1E, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 5'h03, 5'h1C, 5'h03, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 5'h00, 5'h0A, 5'h0A, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 5'h1F, 5'h05, 5'h1F, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 5'h00, 5'h11, 5'h11, 1'b0};

      repeat (2) @(negedge CK);
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_qv", 32'(qv), 32'd0);
      chk("rst_gnt", 32'({gnta, gntb}), 32'd0);
      chk("rst_ack", 32'({acka, ackb}), 32'd0);
      chk("rst_q1", 32'({q1, qv1}), 32'd0);

      do_reset();
      foreach (vecs[i]) run_grant(vecs[i]);

      // Both requesters held high: A,B,A,B with one idle cycle between grants.
      do_reset();
      @(negedge CK);
      REQA = 1'b1;
      REQB = 1'b1;
      DA   = 5'h01;
      DB   = 5'h1E;
      sb.push_back('{q: 5'h01, a: 1'b1});
      sb.push_back('{q: 5'h1E, a: 1'b0});
      sb.push_back('{q: 5'h01, a: 1'b1});
      sb.push_back('{q: 5'h1E, a: 1'b0});
      ngr = 0;
      idle_run = 0;
      prev = 1'b0;
      for (int c = 0; c < 19; c++) begin
         @(negedge CK);
         if (qv && !prev && sb.size() > 0) begin
            e = sb.pop_front();
            chk("alt_q", 32'(q), 32'(e.q));
            chk("alt_gnta", 32'(gnta), 32'(e.a));
            if (ngr > 0) chk("alt_gap", 32'(idle_run), 32'd1);
            ngr++;
         end
         if (qv) idle_run = 0;
         else idle_run++;
         prev = qv;
      end
      chk("alt_count", 32'(ngr), 32'd4);
      sb.delete();
      REQA = 1'b0;
      REQB = 1'b0;

      // Abort at the second hold cycle; LAST keeps A so B wins the next contention.
      do_reset();
      @(negedge CK);
      REQA = 1'b1;
      DA   = 5'h07;
      @(negedge CK);
      chk("abort_gnta", 32'({qv, gnta}), 32'd3);
      @(negedge CK);
      chk("abort_ack2", 32'(acka), 32'd0);
      REQA = 1'b0;
      @(negedge CK);
      chk("abort_qv", 32'(qv), 32'd0);
      chk("abort_gnt", 32'({gnta, gntb}), 32'd0);
      chk("abort_ack", 32'(acka), 32'd0);
      chk("abort_q", 32'(q), 32'h07);
      REQA = 1'b1;
      REQB = 1'b1;
      DB   = 5'h12;
      @(negedge CK);
      chk("abort_next_gntb", 32'(gntb), 32'd1);
      chk("abort_next_q", 32'(q), 32'h12);
      REQA = 1'b0;
      REQB = 1'b0;
      repeat (2) @(negedge CK);

      // EN gates grants only in idle.
      do_reset();
      EN   = 1'b0;
      REQA = 1'b1;
      DA   = 5'h19;
      for (int i = 0; i < 10; i++) begin
         @(negedge CK);
         chk("en_block", 32'(qv), 32'd0);
      end
      EN = 1'b1;
      @(negedge CK);
      chk("en_grant", 32'({qv, gnta}), 32'd3);
      chk("en_q", 32'(q), 32'h19);
      @(negedge CK);
      EN = 1'b0;
      chk("en_ack2", 32'(acka), 32'd0);
      @(negedge CK);
      chk("en_ack3", 32'(acka), 32'd0);
      @(negedge CK);
      chk("en_ack4", 32'(acka), 32'd1);
      REQA = 1'b0;
      @(negedge CK);
      chk("en_done", 32'(qv), 32'd0);
      EN = 1'b1;

      // Reset at CNT=2 abandons the transfer; a held REQA is granted right after release.
      do_reset();
      @(negedge CK);
      REQA = 1'b1;
      DA   = 5'h0D;
      @(negedge CK);
      @(negedge CK);
      RSTN = 1'b0;
      #1;
      chk("rst_no_async", 32'(qv), 32'd1);
      @(negedge CK);
      chk("rst_hold_q", 32'(q), 32'd0);
      chk("rst_hold_qv", 32'(qv), 32'd0);
      chk("rst_hold_ack", 32'(acka), 32'd0);
      RSTN = 1'b1;
      @(negedge CK);
      chk("rst_rel_grant", 32'({qv, gnta}), 32'd3);
      chk("rst_rel_q", 32'(q), 32'h0D);
      REQA = 1'b0;
      repeat (2) @(negedge CK);

      // HOLD=1 instance: valid and ack in the same single cycle.
      do_reset();
      @(negedge CK);
      REQB = 1'b1;
      DB   = 5'h0A;
      @(negedge CK);
      REQB = 1'b0;
      chk("h1_q", 32'(q1), 32'h0A);
      chk("h1_qv", 32'(qv1), 32'd1);
      chk("h1_gntb", 32'(gntb1), 32'd1);
      chk("h1_ackb", 32'(ackb1), 32'd1);
      chk("h1_acka", 32'(acka1), 32'd0);
      @(negedge CK);
      chk("h1_post_qv", 32'(qv1), 32'd0);
      chk("h1_post_q", 32'(q1), 32'h0A);
      chk("h1_post_ack", 32'(ackb1), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/oreg_sched.md
OREG_SCHED -- requirements
Module: oreg_sched

Interface
REQ-001 The block SHALL take parameter HOLD, default 4, meaning the number of cycles a granted word is presented on Q (legal range 1..16).
REQ-002 The block SHALL take parameter W, default 5, meaning the output word width.
REQ-003 CK  input  1  sole clock; all state changes on the rising edge.
REQ-004 RSTN  input  1  reset; synchronous and active-low (sampled on the CK rising edge).
REQ-005 EN  input  1  grant enable; when low, no new grant is issued.
REQ-006 REQA  input  1  requester A wants the output; held high until ACKA.
REQ-007 DA  input  W  requester A data word.
REQ-008 REQB  input  1  requester B wants the output; held high until ACKB.
REQ-009 DB  input  W  requester B data word.
REQ-010 Q  output  W  registered output word (output flop bank).
REQ-011 QV  output  1  Q carries a currently granted word.
REQ-012 GNTA / GNTB  output  1 each  current owner of Q; one-hot or both low.
REQ-013 ACKA / ACKB  output  1 each  one-cycle completion pulse to the owner.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and HOLD, plus a 4-bit down-counter CNT and a 1-bit round-robin pointer LAST (last-served requester).
REQ-015 In IDLE with EN=1 and at least one REQ high at edge t, the block SHALL grant one requester, load Q from its D, load CNT=HOLD-1 and enter HOLD, so Q, QV=1 and GNTx=1 are visible in cycle t+1.
REQ-016 Arbitration SHALL be round-robin: a lone requester wins; if both are high, the requester not equal to LAST wins; LAST updates on every grant.
REQ-017 In HOLD, Q SHALL stay constant; changes on DA/DB after the grant SHALL have no effect.
REQ-018 In HOLD with CNT!=0 and the owner's REQ high, CNT SHALL decrement by one per cycle.
REQ-019 ACKx SHALL be high exactly when state=HOLD, CNT=0 and x is the owner, decoded from registers only; ACK is therefore coincident with the last QV cycle.
REQ-020 QV SHALL be high for exactly HOLD consecutive cycles per completed grant; with HOLD=1, ACK is high in the first QV cycle.
REQ-021 From HOLD with CNT=0, the next state SHALL be IDLE with QV=0 and GNTA=GNTB=0, while Q retains its last value.
REQ-022 A REQ still high in the IDLE cycle after its ACK SHALL be treated as a new request, subject to round-robin.
REQ-023 Abort: in HOLD with CNT!=0 and the owner's REQ low, the next state SHALL be IDLE with no ACK, QV=0, GNT cleared and Q retained; LAST SHALL keep the aborted owner.
REQ-024 EN low SHALL block grants in IDLE only; an active HOLD SHALL run to completion or abort regardless of EN.
REQ-025 The non-owner's REQ and D SHALL be ignored during HOLD; its ACK SHALL remain low.
REQ-026 An illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-027 With RSTN=0 at a rising edge, the block SHALL set state=IDLE, CNT=0, Q=0, QV=0, GNTA=GNTB=0 and LAST=B, so A wins the first contended grant.
REQ-028 Reset asserted mid-HOLD SHALL abandon the transfer with no ACK; RSTN SHALL have no asynchronous effect between edges.
REQ-029 A REQ held high through reset release SHALL be granted on the first edge with RSTN=1 and EN=1.

Verification
REQ-030 HOLD=4: REQA=1, DA=5'h15 at t -> Q=5'h15, QV=1, GNTA=1 for t+1..t+4; ACKA=1 only at t+4; QV=0 at t+5 and Q stays 5'h15.
REQ-031 Both REQ high continuously after reset, DA=5'h01, DB=5'h1E -> grants alternate A,B,A,B; Q alternates 01,1E with one IDLE cycle between grants.
REQ-032 HOLD=1: REQB pulse with DB=5'h0A -> Q=5'h0A, QV=1 and ACKB=1 in the same single cycle.
REQ-033 Abort: REQA grant, REQA dropped at the second HOLD cycle -> QV=0 on the next edge, ACKA never asserted; REQA+REQB together next -> B is granted.
REQ-034 EN=0 with REQA high -> no grant for 10 cycles; EN=1 -> grant on the next edge; EN dropped mid-HOLD -> ACK still issued on schedule.
REQ-035 RSTN=0 during HOLD at CNT=2 -> next edge Q=0, QV=0, no ACK; RSTN=1 with REQA still high -> A is granted on the first edge after release.
